// File: rtl/nbit_arb_mux_if.sv
// Channel-side and output-side bus of nbit_arb_mux.
// slave: seen by the arbiter; master: seen by the upstream/downstream driver.
interface nbit_arb_mux_if #(
  parameter int n  = 8,
  parameter int CH = 4
);
  // Width of sel/out_ch: max(1, clog2(CH)).
  localparam int SW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH*n-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [SW-1:0]   sel;
  logic [n-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_ch;

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/nbit_arb_mux.sv
// N-channel arbitrating mux with a single registered output stage.
// MODE 0: channel picked by sel. MODE 1: round-robin starting at rr_ptr.
module nbit_arb_mux #(
  parameter int n    = 8,
  parameter int CH   = 4,
  parameter int MODE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  nbit_arb_mux_if.slave  bus
);
  localparam int SW = (CH > 1) ? $clog2(CH) : 1;

  logic          can_load;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [n-1:0]  grant_word;

  logic          out_valid_q, out_valid_d;
  logic [n-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic [SW-1:0] rr_ptr_q,    rr_ptr_d;

  // Arbitration: pick the granted channel, gated by can_load and reset.
  always_comb begin
    int unsigned pos;
    grant_vld = 1'b0;
    grant_idx = '0;
    pos       = 0;
    can_load  = !out_valid_q || bus.out_ready;
    if (MODE == 0) begin
      for (int unsigned k = 0; k < CH; k++) begin
        if (bus.sel == SW'(k) && bus.in_valid[k]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(k);
        end
      end
    end else begin
      // Walk from the farthest offset back to rr_ptr so the nearest
      // requester in search order is the last (winning) assignment.
      for (int unsigned off = CH; off > 0; off--) begin
        pos = int'(rr_ptr_q) + off - 1;
        if (pos >= CH) pos = pos - CH;
        if (bus.in_valid[pos]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(pos);
        end
      end
    end
    if (!can_load || !rst_n) begin
      grant_vld = 1'b0;
      grant_idx = '0;
    end
  end

  // One-hot ready toward the granted channel.
  always_comb begin
    bus.in_ready = '0;
    if (grant_vld) bus.in_ready[grant_idx] = 1'b1;
  end

  // Word mux for the granted channel.
  always_comb begin
    grant_word = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (grant_idx == SW'(k)) grant_word = bus.in_data[k*n +: n];
    end
  end

  // Next state of the output stage and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant_vld) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_word;
      out_ch_d    = grant_idx;
      if (MODE != 0) begin
        rr_ptr_d = (grant_idx == SW'(CH - 1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_nbit_arb_mux.sv
// Directed bench: MODE 0 with CH=4 and CH=3, MODE 1 with CH=4.
module tb_nbit_arb_mux;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  nbit_arb_mux_if #(.n(8), .CH(4)) ia ();
  nbit_arb_mux_if #(.n(8), .CH(3)) ib ();
  nbit_arb_mux_if #(.n(8), .CH(4)) ic ();

  nbit_arb_mux #(.n(8), .CH(4), .MODE(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  nbit_arb_mux #(.n(8), .CH(3), .MODE(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  nbit_arb_mux #(.n(8), .CH(4), .MODE(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ia.in_data = '0; ia.in_valid = '0; ia.sel = '0; ia.out_ready = 1'b0;
    ib.in_data = '0; ib.in_valid = '0; ib.sel = '0; ib.out_ready = 1'b0;
    ic.in_data = '0; ic.in_valid = '0; ic.sel = '0; ic.out_ready = 1'b0;

    // Reset: requests present, ready must stay low, outputs zero
    ia.in_valid = 4'hF; ia.out_ready = 1'b1;
    ic.in_valid = 4'hF; ic.out_ready = 1'b1;
    #2;
    chk("rst_a_in_ready", ia.in_ready, 0);
    chk("rst_c_in_ready", ic.in_ready, 0);
    chk("rst_a_out_valid", ia.out_valid, 0);
    chk("rst_a_out_data", ia.out_data, 0);
    chk("rst_c_out_ch", ic.out_ch, 0);
    @(posedge clk); #1;
    chk("rst_c_held_valid", ic.out_valid, 0);
    chk("rst_a_held_valid", ia.out_valid, 0);
    @(negedge clk);
    ia.in_valid = '0; ic.in_valid = '0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_a_ready", ia.in_ready, 0);

    // MODE 0 basic select
    @(negedge clk);
    ia.sel = 2'd2; ia.in_valid = 4'b0100; ia.in_data = 32'h44A52211; ia.out_ready = 1'b1;
    #1;
    chk("m0_in_ready", ia.in_ready, 4'b0100);
    @(posedge clk); #1;
    chk("m0_out_valid", ia.out_valid, 1);
    chk("m0_out_data", ia.out_data, 8'hA5);
    chk("m0_out_ch", ia.out_ch, 2);
    @(negedge clk);
    ia.in_valid = '0;
    @(posedge clk); #1;
    chk("m0_drain_valid", ia.out_valid, 0);
    chk("m0_drain_data_hold", ia.out_data, 8'hA5);

    // MODE 0, CH=3: out-of-range sel
    @(negedge clk);
    ib.sel = 2'd3; ib.in_valid = 3'b111; ib.out_ready = 1'b1; ib.in_data = 24'h332211;
    #1;
    chk("oor_in_ready", ib.in_ready, 0);
    @(posedge clk); #1;
    chk("oor_out_valid", ib.out_valid, 0);
    @(negedge clk);
    ib.sel = 2'd2;
    #1;
    chk("ch3_in_ready", ib.in_ready, 3'b100);
    @(posedge clk); #1;
    chk("ch3_out_data", ib.out_data, 8'h33);
    chk("ch3_out_ch", ib.out_ch, 2);
    @(negedge clk);
    ib.in_valid = '0;

    // Backpressure on MODE 0
    @(negedge clk);
    ia.sel = 2'd1; ia.in_valid = 4'b0010; ia.in_data = 32'h00003C00; ia.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_load_data", ia.out_data, 8'h3C);
    chk("bp_load_valid", ia.out_valid, 1);
    @(negedge clk);
    ia.out_ready = 1'b0; ia.in_data = 32'h00005A00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", ia.out_data, 8'h3C);
      chk("bp_hold_ch", ia.out_ch, 1);
      chk("bp_hold_valid", ia.out_valid, 1);
      chk("bp_hold_ready", ia.in_ready, 0);
    end
    @(negedge clk);
    ia.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", ia.in_ready, 4'b0010);
    @(posedge clk); #1;
    chk("bp_next_data", ia.out_data, 8'h5A);
    chk("bp_next_valid", ia.out_valid, 1);
    @(negedge clk);
    ia.in_valid = '0;
    @(posedge clk); #1;
    chk("bp_final_valid", ia.out_valid, 0);

    // MODE 1 round-robin, all channels requesting
    @(negedge clk);
    ic.in_data = 32'hD3C2B1A0; ic.in_valid = 4'hF; ic.out_ready = 1'b1;
    #1;
    chk("rr_first_ready", ic.in_ready, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("rr_seq_ch", ic.out_ch, i % 4);
      chk("rr_seq_data", ic.out_data, 8'hA0 + 8'h11 * (i % 4));
    end

    // MODE 1 sparse requests: bring rr_ptr to 2, then ch1/ch3 only
    @(negedge clk);
    ic.in_valid = 4'b0010;
    #1;
    chk("rr_setup_ready", ic.in_ready, 4'b0010);
    @(posedge clk); #1;
    chk("rr_setup_ch", ic.out_ch, 1);
    @(negedge clk);
    ic.in_valid = 4'b1010;
    #1;
    chk("rr_sparse_ready3", ic.in_ready, 4'b1000);
    @(posedge clk); #1;
    chk("rr_sparse_ch3", ic.out_ch, 3);
    chk("rr_ptr0_ready1", ic.in_ready, 4'b0010);
    @(posedge clk); #1;
    chk("rr_sparse_ch1", ic.out_ch, 1);
    chk("rr_ptr2_ready3", ic.in_ready, 4'b1000);

    // Reset mid-operation with a word held
    @(negedge clk);
    chk("mid_pre_valid", ic.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ic.out_valid, 0);
    chk("mid_rst_data", ic.out_data, 0);
    chk("mid_rst_ch", ic.out_ch, 0);
    chk("mid_rst_ready", ic.in_ready, 0);
    @(posedge clk); #1;
    chk("mid_rst_edge_valid", ic.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ic.in_valid = 4'hF;
    #1;
    chk("mid_rel_ready", ic.in_ready, 4'b0001);
    @(posedge clk); #1;
    chk("mid_rel_ch", ic.out_ch, 0);
    chk("mid_rel_data", ic.out_data, 8'hA0);
    chk("mid_rel_valid", ic.out_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nbit_arb_mux.md
NBIT_ARB_MUX -- requirements
Module: nbit_arb_mux

Interface
REQ-001 Parameter n SHALL default to 8 and set the data width per channel in bits (n >= 1).
REQ-002 Parameter CH SHALL default to 4 and set the number of input channels (CH >= 2).
REQ-003 Parameter MODE SHALL default to 0 and select arbitration: 0 = external select via sel, 1 = round-robin.
REQ-004 Constant SW = max(1, clog2(CH)) SHALL set the width of sel and out_ch.
REQ-005 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port in_data, input, CH*n: packed channel data; channel k occupies bits [k*n+n-1 : k*n].
REQ-008 Port in_valid, input, CH: bit k high means channel k offers a word.
REQ-009 Port in_ready, output, CH: bit k high means channel k's word is accepted this cycle.
REQ-010 Port sel, input, SW: requested channel in MODE 0; ignored in MODE 1.
REQ-011 Port out_data, output, n: registered selected word.
REQ-012 Port out_valid, output, 1: out_data holds a word not yet consumed.
REQ-013 Port out_ready, input, 1: downstream consumes out_data when high together with out_valid.
REQ-014 Port out_ch, output, SW: index of the channel that supplied out_data.

Function
REQ-015 The block SHALL have one output register stage (out_data, out_ch, out_valid) and, in MODE 1, a round-robin pointer rr_ptr of width SW.
REQ-016 can_load SHALL be high when out_valid = 0 or out_ready = 1.
REQ-017 MODE 0: grant SHALL be sel when sel < CH, in_valid[sel] = 1 and can_load = 1; otherwise there is no grant.
REQ-018 A sel value >= CH SHALL produce no grant; all in_ready bits stay 0.
REQ-019 MODE 1: grant SHALL go to the first channel with in_valid high, searching rr_ptr, rr_ptr+1, ..., CH-1, 0, ..., rr_ptr-1, and only when can_load = 1.
REQ-020 MODE 1: on a grant to channel g, rr_ptr SHALL become g+1, wrapping from CH-1 to 0; with no grant, rr_ptr SHALL hold.
REQ-021 in_ready SHALL be combinational, one-hot at the granted channel, and all zero when there is no grant; at most one bit is high per cycle.
REQ-022 On a grant, the next edge SHALL load out_data with the granted channel's word, out_ch with g, and set out_valid = 1 (latency 1 cycle).
REQ-023 With no grant and out_valid = 1, out_ready = 1, the next edge SHALL clear out_valid.
REQ-024 While out_valid = 1 and out_ready = 0, out_data and out_ch SHALL hold stable and in_ready SHALL be all zero.
REQ-025 A simultaneous drain and new grant SHALL sustain one word per cycle with no bubble.
REQ-026 in_valid on a non-granted channel SHALL have no effect on any state.
REQ-027 out_data and out_ch SHALL be don't-care while out_valid = 0, but SHALL only change on a load.
REQ-028 With in_valid held high and out_ready held high, MODE 1 SHALL serve every requesting channel within CH consecutive grants.

Reset
REQ-029 rst_n = 0 SHALL immediately, without waiting for a clock edge, force out_valid = 0, out_data = 0, out_ch = 0 and rr_ptr = 0.
REQ-030 During reset, in_ready SHALL be all zero.
REQ-031 A word held in the output register when reset asserts SHALL be discarded; no partial transfer SHALL survive reset.
REQ-032 The first grant after reset release SHALL occur no earlier than the first rising edge with rst_n = 1.

Verification
REQ-033 MODE 0, n=8, CH=4: sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
REQ-034 MODE 0, CH=3: sel=3, all in_valid=1 -> in_ready=0; out_valid stays 0.
REQ-035 MODE 1, CH=4: all in_valid=1 and out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3.
REQ-036 Backpressure: out_valid=1 with out_data=8'h3C, out_ready=0 for 5 cycles -> out_data stays 8'h3C, in_ready=0; out_ready=1 -> the next word loads on the following edge with no bubble.
REQ-037 MODE 1: only ch1 and ch3 valid, rr_ptr=2 -> grant ch3, rr_ptr becomes 0; next grant ch1, rr_ptr becomes 2.
REQ-038 Reset mid-operation: drop rst_n between edges while out_valid=1 -> out_valid=0 and out_data=0 before the next edge; after release, MODE 1 grants ch0 first.
